// File: rtl/iob_fifo_arb_pkg.sv
// ============================================================================
//  Module      : iob_fifo_arb_pkg
//  Description : Shared types and helpers for the FIFO write-port arbiter.
//                - state_e        : arbiter state encoding (IDLE / BURST)
//                - gnt_w()        : grant-index width for a requester count
//                - `IOB_FIFO_ARB_FREE(AW, LVL) : free FIFO words, AW+1 bits
//                The free-space helper is only referenced when the arbiter
//                is built with IOB_FIFO_ARB_SPACE_CHECK_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Free space of a FIFO holding at most 2^AW-1 words, given its current
// level. Result is AW+1 bits wide so it can be compared against burst sizes.
`ifndef IOB_FIFO_ARB_FREE
`define IOB_FIFO_ARB_FREE(AW, LVL) \
    ((((AW)+1)'((1 << (AW)) - 1)) - (((AW)+1)'(LVL)))
`endif

package iob_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int gnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_rr_pick.sv
// ============================================================================
//  Module      : iob_rr_pick
//  Description : Combinational rotating-priority picker. Returns the first
//                asserted request found when searching ptr_i, ptr_i+1, ...
//                (mod N_REQ).
//  Ports       : req_i [N_REQ]  request vector
//                ptr_i [GNT_W]  highest-priority index (must be < N_REQ)
//                any_o          at least one request asserted
//                idx_o [GNT_W]  selected index (0 when any_o is low)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_rr_pick
    import iob_fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int GNT_W = gnt_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [GNT_W-1:0] ptr_i,
    output logic             any_o,
    output logic [GNT_W-1:0] idx_o
);

    localparam logic [GNT_W:0] N_EXT = (GNT_W+1)'(N_REQ);

    // w_cand[k] is the index examined at search offset k.
    logic [GNT_W-1:0] w_cand [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
        logic [GNT_W:0] w_sum;
        assign w_sum     = {1'b0, ptr_i} + (GNT_W+1)'(k);
        assign w_cand[k] = (w_sum >= N_EXT) ? GNT_W'(w_sum - N_EXT)
                                            : GNT_W'(w_sum);
    end

    // Walk from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[w_cand[k]]) begin
                idx_o = w_cand[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/iob_fifo_wr_arb.sv
// ============================================================================
//  Module      : iob_fifo_wr_arb
//  Description : Round-robin arbiter sharing the write port of an async FIFO
//                between N_REQ requesters. A grant covers a whole burst of
//                req_len+1 words; transfers are paced by the FIFO full flag.
//                Optional macro IOB_FIFO_ARB_SPACE_CHECK_EN: only grant a
//                requester whose whole burst fits in the FIFO free space.
//  Ports       : clk_i, rst_ni          write clock, async active-low reset
//                req_valid_i [N]        per-requester word valid
//                req_len_i   [N*LEN_W]  burst length minus one (at grant)
//                req_data_i  [N*DATA_W] per-requester write word
//                req_ready_o [N]        per-requester word accept
//                fifo_w_data_o, fifo_write_en_o  to FIFO write port
//                fifo_full_i, fifo_level_w_i     from FIFO write side
//                grant_id_o             current owner (valid while busy_o)
//                busy_o                 burst in progress
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_fifo_wr_arb
    import iob_fifo_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4,
    localparam int GNT_W = gnt_w(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*LEN_W-1:0]  req_len_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       fifo_w_data_o,
    output logic                    fifo_write_en_o,
    input  logic                    fifo_full_i,
    input  logic [ADDR_W-1:0]       fifo_level_w_i,
    output logic [GNT_W-1:0]        grant_id_o,
    output logic                    busy_o
);

    state_e           state_q, state_d;
    logic [GNT_W-1:0] grant_q, grant_d;
    logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] w_elig;
    logic             w_pick_any;
    logic [GNT_W-1:0] w_pick_idx;
    logic             w_owner_valid;
    logic             w_xfer;

`ifdef IOB_FIFO_ARB_SPACE_CHECK_EN
    localparam int CMP_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    logic [ADDR_W:0] w_free;
    assign w_free = `IOB_FIFO_ARB_FREE(ADDR_W, fifo_level_w_i);

    // A requester is eligible only if its entire burst fits right now, so a
    // granted burst can never run into fifo_full.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_valid_i[i] &&
                ((CMP_W'(req_len_i[i*LEN_W +: LEN_W]) + CMP_W'(1))
                 <= CMP_W'(w_free));
        end
    end
`else
    // Level is not needed without the space check; fold it to keep it tied.
    logic w_unused_level;
    assign w_unused_level = ^fifo_level_w_i;
    assign w_elig         = req_valid_i;
`endif

    iob_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i (w_elig),
        .ptr_i (rr_ptr_q),
        .any_o (w_pick_any),
        .idx_o (w_pick_idx)
    );

    assign w_owner_valid = req_valid_i[grant_q];
    assign w_xfer        = (state_q == BURST) && w_owner_valid && !fifo_full_i;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        cnt_d           = cnt_q;
        rr_ptr_d        = rr_ptr_q;
        req_ready_o     = '0;
        fifo_w_data_o   = '0;
        fifo_write_en_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    state_d = BURST;
                    grant_d = w_pick_idx;
                    cnt_d   = req_len_i[int'(w_pick_idx)*LEN_W +: LEN_W];
                end
            end
            BURST: begin
                req_ready_o[grant_q] = !fifo_full_i;
                fifo_w_data_o        = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
                fifo_write_en_o      = w_owner_valid && !fifo_full_i;
                if (w_xfer) begin
                    if (cnt_q == '0) begin
                        // Last word: hand priority to the next requester.
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == GNT_W'(N_REQ - 1))
                                   ? '0 : grant_q + GNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign busy_o     = (state_q == BURST);
    assign grant_id_o = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_fifo_wr_arb.sv
// ============================================================================
//  Module      : tb_iob_fifo_wr_arb
//  Description : Self-checking bench for iob_fifo_wr_arb. Stimulus pushes the
//                expected FIFO words into a queue; a monitor pops and compares
//                on every FIFO write. Each producer emits {id, sequence} words
//                so duplicated or dropped words are visible.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_fifo_wr_arb;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;
    localparam int GNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       fifo_w_data;
    logic                    fifo_write_en;
    logic                    fifo_full;
    logic [ADDR_W-1:0]       fifo_level_w;
    logic [GNT_W-1:0]        grant_id;
    logic                    busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q [$];
    logic [23:0] seq     [N_REQ] = '{default: '0};
    logic [23:0] exp_seq [N_REQ] = '{default: '0};

    always #5 clk = ~clk;

    iob_fifo_wr_arb #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_len_i       (req_len),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .fifo_w_data_o   (fifo_w_data),
        .fifo_write_en_o (fifo_write_en),
        .fifo_full_i     (fifo_full),
        .fifo_level_w_i  (fifo_level_w),
        .grant_id_o      (grant_id),
        .busy_o          (busy)
    );

    // Producers: word = {id, running count of accepted words}.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = {8'(i), seq[i]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) seq[i] <= seq[i] + 24'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({8'(id), exp_seq[id]});
            exp_seq[id] = exp_seq[id] + 24'd1;
        end
    endtask

    task automatic set_len(input int id, input int len);
        req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step until the current burst has finished, then drop all requests
    // before the next edge can grant again.
    task automatic wait_idle_drop(input string name);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!busy) break;
        end
        check(name, 32'(busy), 32'd0);
        req_valid = '0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [31:0] w;
        if (rst_n === 1'b1 && fifo_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got 0x%0h expected no write",
                         fifo_w_data);
            end else begin
                w = exp_q.pop_front();
                check("wr_data", fifo_w_data, w);
                check("wr_grant", 32'(grant_id), 32'(w[31:24]));
                check("wr_ready", 32'(req_ready[grant_id]), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_len      = '0;
        fifo_full    = 1'b0;
        fifo_level_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_we",    32'(fifo_write_en), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wdata", fifo_w_data, 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        tick();
        rst_n = 1'b1;

        // T1: two len-0 requesters, rotation 0,2,0.
        req_valid = 4'b0101;
        push_exp(0, 1); push_exp(2, 1); push_exp(0, 1);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_we", 32'(fifo_write_en), 32'd0);
        @(posedge clk); @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_g0", 32'(grant_id), 32'd0);
        @(posedge clk); @(negedge clk);
        check("t1_gap", 32'(busy), 32'd0);
        @(posedge clk); @(negedge clk);
        check("t1_g2", 32'(grant_id), 32'd2);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("t1_g0b", 32'(grant_id), 32'd0);
        tick();
        req_valid = '0;
        drain("t1_drain");

        // T2: requester 1, 4-word burst, then back-to-back 1-word burst.
        tick();
        set_len(1, 3);
        req_valid = 4'b0010;
        push_exp(1, 4);
        @(negedge clk);
        check("t2_idle", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            check("t2_we", 32'(fifo_write_en), 32'd1);
            check("t2_busy", 32'(busy), 32'd1);
        end
        tick();
        set_len(1, 0);
        push_exp(1, 1);
        @(negedge clk);
        check("t2_end_busy", 32'(busy), 32'd0);
        check("t2_end_we", 32'(fifo_write_en), 32'd0);
        @(posedge clk); @(negedge clk);
        check("t2_regrant", 32'(grant_id), 32'd1);
        tick();
        req_valid = '0;
        drain("t2_drain");

        // T3: fifo_full stall for burst cycles 2-3.
        tick();
        set_len(2, 3);
        req_valid = 4'b0100;
        push_exp(2, 4);
        @(posedge clk); @(negedge clk);
        check("t3_ready", 32'(req_ready), 32'h4);
        tick();
        fifo_full = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t3_stall_ready", 32'(req_ready), 32'd0);
            check("t3_stall_we", 32'(fifo_write_en), 32'd0);
            check("t3_stall_busy", 32'(busy), 32'd1);
            @(posedge clk);
        end
        #1 fifo_full = 1'b0;
        wait_idle_drop("t3_end");
        drain("t3_drain");

        // T4: owner 0 drops valid mid-burst while requester 3 waits.
        tick();
        set_len(0, 2);
        req_valid = 4'b0001;
        push_exp(0, 3);
        @(posedge clk); @(posedge clk);
        #1;
        set_len(3, 0);
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_grant", 32'(grant_id), 32'd0);
            check("t4_hold_busy", 32'(busy), 32'd1);
            check("t4_hold_we", 32'(fifo_write_en), 32'd0);
            check("t4_hold_ready", 32'(req_ready), 32'h1);
            @(posedge clk);
        end
        #1 req_valid = 4'b1001;
        @(posedge clk); @(posedge clk);
        #1 req_valid = 4'b1000;
        push_exp(3, 1);
        @(negedge clk);
        check("t4_idle", 32'(busy), 32'd0);
        @(posedge clk); @(negedge clk);
        check("t4_g3", 32'(grant_id), 32'd3);
        tick();
        req_valid = '0;
        drain("t4_drain");

        // T5: reset during a burst of requester 2 (2 of 8 words written).
        tick();
        set_len(0, 0);
        req_valid = 4'b0001;
        push_exp(0, 1);
        @(posedge clk); @(posedge clk);
        #1;
        set_len(2, 7);
        req_valid = 4'b0100;
        push_exp(2, 2);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_we", 32'(fifo_write_en), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_len(2, 0);
        req_valid = 4'b0101;
        push_exp(0, 1);
        @(posedge clk); @(negedge clk);
        check("t5_rr_restart", 32'(grant_id), 32'd0);
        tick();
        req_valid = '0;
        drain("t5_drain");

`ifdef IOB_FIFO_ARB_SPACE_CHECK_EN
        // T6: space check with level 12 (free 3).
        tick();
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        fifo_level_w = 4'd12;
        set_len(0, 7);
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_no_elig", 32'(busy), 32'd0);
        end
        tick();
        set_len(1, 1);
        req_valid = 4'b0011;
        push_exp(1, 2);
        @(posedge clk); @(negedge clk);
        check("t6_g1", 32'(grant_id), 32'd1);
        @(posedge clk); @(posedge clk);
        #1;
        fifo_level_w = 4'd0;
        req_valid    = 4'b0001;
        push_exp(0, 8);
        @(posedge clk); @(negedge clk);
        check("t6_g0", 32'(grant_id), 32'd0);
        wait_idle_drop("t6_end");
        drain("t6_drain");
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iob_fifo_wr_arb.md
Name: iob_fifo_wr_arb

Overview:
- Round-robin arbiter that shares the write port of an asynchronous (optionally asymmetric) FIFO between N_REQ requesters in the write clock domain.
- Grants the write port for a whole burst. Sequences word transfers against the FIFO full flag. Returns to arbitration after the last word.
- Sits between producer engines and the FIFO write port (w_data, write_en, full, level_w). Runs entirely on the FIFO write clock.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 32, FIFO write data width (FIFO W_DATA_W).
- ADDR_W, 8, FIFO write-side address width (FIFO W_ADDR_W). The FIFO holds at most 2^ADDR_W-1 words.
- LEN_W, 4, burst length field width. Burst = req_len+1 words (1..2^LEN_W).

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester word valid; a request is pending while high.
- req_len  in  N_REQ*LEN_W  per-requester burst length minus one; sampled at grant.
- req_data  in  N_REQ*DATA_W  per-requester write word.
- req_ready  out  N_REQ  per-requester word accept.
- fifo_w_data  out  DATA_W  to FIFO w_data.
- fifo_write_en  out  1  to FIFO write_en.
- fifo_full  in  1  from FIFO full.
- fifo_level_w  in  ADDR_W  from FIFO level_w.
- grant_id  out  $clog2(N_REQ)  index of current owner; valid while busy.
- busy  out  1  burst in progress.

Behaviour:
- States:
  - IDLE: no owner.
  - BURST: owner holds the port.
- Registers: state, grant_id, word counter cnt[LEN_W-1:0], rotating pointer rr_ptr.
- Reset (rst low, async): state=IDLE, grant_id=0, cnt=0, rr_ptr=0. busy=0, req_ready=0, fifo_write_en=0, fifo_w_data=0 (zero while not BURST).
- Selection in IDLE:
  - Pick the first index i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Next edge: state=BURST, grant_id=i, cnt=req_len[i].
  - Grant latency is 1 cycle. No word moves in the IDLE cycle.
- BURST:
  - req_ready[grant_id] = ~fifo_full. All other req_ready=0.
  - fifo_w_data = req_data[grant_id] (combinational mux).
  - fifo_write_en = req_valid[grant_id] & ~fifo_full.
  - Each transfer with cnt!=0 decrements cnt.
  - A transfer with cnt==0 is the last word. Next edge: state=IDLE, rr_ptr=(grant_id+1) mod N_REQ.
  - The next grant therefore occurs at the earliest 1 cycle after the last word. The bus has one idle cycle between bursts.
- Owner drops req_valid mid-burst: grant held, nothing written, cnt unchanged. No timeout.
- fifo_full high: stall. Ready low, cnt frozen. Resumes on the first cycle full is low.
- req_len of non-owners is ignored. The owner's req_len is ignored after the grant edge.
- A single requester asserting continuously gets back-to-back bursts separated by one IDLE cycle.
- Reset mid-burst: immediate return to IDLE. The partial burst is abandoned. Words already written stay in the FIFO.
- Width rule: grant_id is $clog2(N_REQ) bits. The rr_ptr wrap uses an explicit compare with N_REQ-1, not a power-of-two mask.

Optional Feature:
- Macro: IOB_FIFO_ARB_SPACE_CHECK_EN.
- Defined:
  - Free space is computed as free = (2^ADDR_W-1) - fifo_level_w, in ADDR_W+1 bits.
  - In IDLE, requester i is eligible only if req_valid[i] and (req_len[i]+1) <= free.
  - The rotating search skips ineligible requesters. Once granted, a burst never sees fifo_full.
  - If no requester is eligible, stay in IDLE.
- Undefined:
  - Eligibility = req_valid only. Stalls occur via fifo_full inside BURST as described above.

Decomposition:
- Shared package iob_fifo_arb_pkg:
  - State encoding localparams: IDLE=1'b0, BURST=1'b1.
  - Macro helper for the free-space computation.
  - GNT_W = $clog2(N_REQ) formula.
- One sub-module: iob_rr_pick.
  - Purely combinational rotating-priority picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: any, idx.
  - Instantiated once for IDLE selection.

Test Plan:
- Reset, then req_valid=4'b0101 with len 0 on both -> grant 0 one cycle later, one word written. Then grant 2, then grant 0 again. rr_ptr order 0,2,0.
- Single requester 1, req_len=3, continuous valid, fifo_full=0 -> exactly 4 consecutive fifo_write_en pulses carrying req_data[1]. busy deasserts the cycle after the 4th.
- Burst of 4 with fifo_full forced high for cycles 2-3 of the burst -> req_ready low and cnt frozen during the stall. Total 4 writes. No word duplicated or dropped (checked via a scoreboard).
- Owner drops req_valid for 5 cycles mid-burst while requester 3 is valid -> grant_id stays at owner. Requester 3 gets no grant until the owner's burst ends.
- rst pulsed low mid-burst (2 of 8 words written) -> busy=0, fifo_write_en=0 immediately. After release, arbitration restarts with rr_ptr=0.
- With IOB_FIFO_ARB_SPACE_CHECK_EN, ADDR_W=4, fifo_level_w=12 (free=3):
  - req 0 with len=7 and req 1 with len=1 -> requester 1 granted, requester 0 skipped.
  - Then level_w=0 -> requester 0 granted.
